// File: rtl/mem_writeback.sv
// Memory/writeback stage: one instruction slot, data-memory req/ready + rvalid access,
// load alignment/extension, register-file write and forwarding. Optional macro: MISALIGN_TRAP_EN.
module mem_writeback #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_store_data,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_we,
  output logic              dmem_req,
  input  logic              dmem_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [31:0]       rf_wd,
  output logic              fwd_reg_we,
  output logic [4:0]        fwd_rd,
  output logic [31:0]       fwd_data,
  output logic              misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_q;
  logic              slot_q;
  logic              is_load_q;
  logic              wr_q;
  logic              err_q;
  logic [4:0]        rd_q;
  logic [2:0]        funct3_q;
  logic [31:0]       result_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wmask_q;
  logic [31:0]       wdata_q;

  logic        complete;
  logic        accept;
  logic        size_byte;
  logic        size_half;
  logic        misaligned;
  logic        trap_d;
  logic        mem_op_d;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_word;
  logic [31:0] wb_data;

  // Access size from funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) word.
  assign size_byte  = (ex_funct3[1:0] == 2'b00);
  assign size_half  = (ex_funct3[1:0] == 2'b01);
  assign misaligned = (size_half && ex_result[0]) ||
                      (!size_byte && !size_half && (ex_result[1:0] != 2'b00));

`ifdef MISALIGN_TRAP_EN
  assign trap_d = (ex_is_load || ex_is_store) && misaligned;
`else
  assign trap_d = 1'b0;
`endif

  assign mem_op_d = (ex_is_load || ex_is_store) && !trap_d;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[gi] = size_byte ? (ex_result[1:0] == gi[1:0]) :
                             size_half ? (ex_result[1] == gi[1]) : 1'b1;
    end
  endgenerate

  always_comb begin
    lane_wdata = ex_store_data;
    if (size_byte)      lane_wdata = {4{ex_store_data[7:0]}};
    else if (size_half) lane_wdata = {2{ex_store_data[15:0]}};
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (result_q[1:0])
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = result_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   ld_word = {{24{ld_byte[7] & ~funct3_q[2]}}, ld_byte};
      2'b01:   ld_word = {{16{ld_half[15] & ~funct3_q[2]}}, ld_half};
      default: ld_word = dmem_rdata;
    endcase
  end

  // A store completes when its request is accepted; a load only when its response arrives.
  assign complete = slot_q && ((state_q == IDLE) ||
                               (state_q == REQ && dmem_ready && !is_load_q) ||
                               (state_q == RESP && dmem_rvalid));
  assign ex_ready = !slot_q || complete;
  assign accept   = ex_valid && ex_ready;

  assign wb_data      = (state_q == RESP) ? ld_word : result_q;
  assign rf_we        = complete && wr_q;
  assign rf_wa        = rf_we ? rd_q : 5'd0;
  assign rf_wd        = rf_we ? wb_data : 32'd0;
  assign fwd_reg_we   = rf_we;
  assign fwd_rd       = rf_wa;
  assign fwd_data     = rf_wd;
  assign misalign_err = slot_q && (state_q == IDLE) && err_q;

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wmask = wmask_q;
  assign dmem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      slot_q    <= 1'b0;
      is_load_q <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 5'd0;
      funct3_q  <= 3'd0;
      result_q  <= 32'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wmask_q   <= 4'd0;
      wdata_q   <= 32'd0;
    end else begin
      case (state_q)
        REQ: begin
          if (dmem_ready) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wmask_q <= 4'd0;
            wdata_q <= 32'd0;
            state_q <= is_load_q ? RESP : IDLE;
          end
        end
        RESP: begin
          if (dmem_rvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (complete) begin
        slot_q <= 1'b0;
        err_q  <= 1'b0;
      end

      // A new capture overrides the retirement above when both happen on one edge.
      if (accept) begin
        slot_q    <= 1'b1;
        is_load_q <= ex_is_load && !trap_d;
        wr_q      <= ex_reg_we && (ex_rd != 5'd0) && !ex_is_store && !trap_d;
        err_q     <= trap_d;
        rd_q      <= ex_rd;
        funct3_q  <= ex_funct3;
        result_q  <= ex_result;
        if (mem_op_d) begin
          state_q <= REQ;
          req_q   <= 1'b1;
          we_q    <= ex_is_store;
          addr_q  <= {ex_result[ADDR_W-1:2], 2'b00};
          wmask_q <= ex_is_store ? lane_mask : 4'd0;
          wdata_q <= ex_is_store ? lane_wdata : 32'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Directed self-checking bench for mem_writeback: ALU, load, store, stall, reset and
// (when MISALIGN_TRAP_EN is defined) misalignment scenarios.
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_funct3;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic        dmem_req;
  logic        dmem_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        fwd_reg_we;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        misalign_err;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_writeback #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_funct3(ex_funct3), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .fwd_reg_we(fwd_reg_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .misalign_err(misalign_err)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled 4 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_result = 0; ex_store_data = 0; ex_funct3 = 0;
    ex_is_load = 0; ex_is_store = 0; ex_rd = 0; ex_reg_we = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] rd, input logic we);
    ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_result = res; ex_store_data = sd; ex_rd = rd; ex_reg_we = we;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    vecs++; if (ex_ready !== 1'b1) begin errs++; $display("FAIL reset_ex_ready got %b exp 1", ex_ready); end
    vecs++; if (dmem_req !== 1'b0) begin errs++; $display("FAIL reset_dmem_req got %b exp 0", dmem_req); end
    vecs++; if (rf_we !== 1'b0 || fwd_reg_we !== 1'b0) begin errs++; $display("FAIL reset_we got %b/%b exp 0/0", rf_we, fwd_reg_we); end
    vecs++; if (dmem_addr !== 32'h0 || dmem_wmask !== 4'h0 || dmem_wdata !== 32'h0) begin errs++; $display("FAIL reset_dmem got %h/%h/%h exp 0", dmem_addr, dmem_wmask, dmem_wdata); end
    vecs++; if (misalign_err !== 1'b0) begin errs++; $display("FAIL reset_misalign got %b exp 0", misalign_err); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_alu_back_to_back();
    issue(0, 0, 3'b000, 32'h11, 32'h0, 5'd5, 1);
    settle();
    vecs++; if (ex_ready !== 1'b1) begin errs++; $display("FAIL alu_ready0 got %b exp 1", ex_ready); end
    tick();
    issue(0, 0, 3'b000, 32'h22, 32'h0, 5'd6, 1);
    settle();
    vecs++; if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'h11) begin errs++; $display("FAIL alu_first got %b/%0d/%h exp 1/5/00000011", rf_we, rf_wa, rf_wd); end
    vecs++; if (fwd_reg_we !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h11) begin errs++; $display("FAIL alu_fwd1 got %b/%0d/%h exp 1/5/00000011", fwd_reg_we, fwd_rd, fwd_data); end
    vecs++; if (ex_ready !== 1'b1) begin errs++; $display("FAIL alu_ready1 got %b exp 1", ex_ready); end
    tick();
    idle_inputs();
    settle();
    vecs++; if (rf_we !== 1'b1 || rf_wa !== 5'd6 || rf_wd !== 32'h22) begin errs++; $display("FAIL alu_second got %b/%0d/%h exp 1/6/00000022", rf_we, rf_wa, rf_wd); end
    vecs++; if (ex_ready !== 1'b1) begin errs++; $display("FAIL alu_ready2 got %b exp 1", ex_ready); end
    tick();
    settle();
    vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL alu_idle_we got %b exp 0", rf_we); end
    tick();
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_wd);
    issue(1, 0, f3, addr, 32'h0, 5'd7, 1);
    tick();
    idle_inputs();
    dmem_ready = 1;
    settle();
    vecs++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {addr[31:2], 2'b00}) begin errs++; $display("FAIL %s_req got %b/%b/%h exp 1/0/%h", name, dmem_req, dmem_we, dmem_addr, {addr[31:2], 2'b00}); end
    vecs++; if (ex_ready !== 1'b0 || fwd_reg_we !== 1'b0) begin errs++; $display("FAIL %s_stall got %b/%b exp 0/0", name, ex_ready, fwd_reg_we); end
    tick();
    dmem_ready = 0; dmem_rvalid = 1; dmem_rdata = rdata;
    settle();
    vecs++; if (dmem_req !== 1'b0) begin errs++; $display("FAIL %s_resp_req got %b exp 0", name, dmem_req); end
    vecs++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== exp_wd) begin errs++; $display("FAIL %s_wb got %b/%0d/%h exp 1/7/%h", name, rf_we, rf_wa, rf_wd, exp_wd); end
    tick();
    idle_inputs();
  endtask

  task automatic test_store_half_stall();
    issue(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 0);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      settle();
      vecs++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200) begin errs++; $display("FAIL sh_req%0d got %b/%b/%h exp 1/1/00000200", i, dmem_req, dmem_we, dmem_addr); end
      vecs++; if (dmem_wmask !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD) begin errs++; $display("FAIL sh_lane%0d got %b/%h exp 1100/abcdabcd", i, dmem_wmask, dmem_wdata); end
      vecs++; if (ex_ready !== (i == 3) || rf_we !== 1'b0) begin errs++; $display("FAIL sh_ready%0d got %b/%b exp %b/0", i, ex_ready, rf_we, (i == 3)); end
      tick();
    end
    dmem_ready = 0;
    settle();
    vecs++; if (dmem_req !== 1'b0) begin errs++; $display("FAIL sh_done_req got %b exp 0", dmem_req); end
    tick();
  endtask

  task automatic test_store_byte();
    issue(0, 1, 3'b000, 32'h101, 32'h0000_00A5, 5'd0, 0);
    tick();
    idle_inputs();
    dmem_ready = 1;
    settle();
    vecs++; if (dmem_wmask !== 4'b0010 || dmem_wdata !== 32'hA5A5_A5A5 || dmem_addr !== 32'h100) begin errs++; $display("FAIL sb_lane got %b/%h/%h exp 0010/a5a5a5a5/00000100", dmem_wmask, dmem_wdata, dmem_addr); end
    tick();
    dmem_ready = 0;
    issue(0, 1, 3'b111, 32'h40, 32'hCAFE_F00D, 5'd0, 0);
    tick();
    idle_inputs();
    dmem_ready = 1;
    settle();
    vecs++; if (dmem_wmask !== 4'b1111 || dmem_wdata !== 32'hCAFE_F00D) begin errs++; $display("FAIL sw_undef_f3 got %b/%h exp 1111/cafef00d", dmem_wmask, dmem_wdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_lw_rd0_and_stray();
    issue(1, 0, 3'b010, 32'h40, 32'h0, 5'd0, 1);
    tick();
    idle_inputs();
    dmem_ready = 1;
    settle();
    tick();
    dmem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      dmem_rvalid = (i == 4); dmem_rdata = 32'hDEAD_BEEF;
      settle();
      vecs++; if (ex_ready !== (i == 4) || rf_we !== 1'b0 || fwd_reg_we !== 1'b0) begin errs++; $display("FAIL lw_rd0_%0d got %b/%b/%b exp %b/0/0", i, ex_ready, rf_we, fwd_reg_we, (i == 4)); end
      tick();
    end
    dmem_rvalid = 1;
    settle();
    vecs++; if (rf_we !== 1'b0 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin errs++; $display("FAIL stray_rvalid got %b/%b/%b exp 0/0/1", rf_we, dmem_req, ex_ready); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_access();
    issue(1, 0, 3'b010, 32'h80, 32'h0, 5'd9, 1);
    tick();
    idle_inputs();
    dmem_ready = 1;
    settle();
    tick();
    dmem_ready = 0;
    rst_n = 0;
    #1;
    vecs++; if (dmem_req !== 1'b0 || rf_we !== 1'b0 || ex_ready !== 1'b1) begin errs++; $display("FAIL rst_mid got %b/%b/%b exp 0/0/1", dmem_req, rf_we, ex_ready); end
    #2;
    rst_n = 1;
    tick();
    dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    settle();
    vecs++; if (rf_we !== 1'b0 || rf_wd !== 32'h0) begin errs++; $display("FAIL rst_late_rvalid got %b/%h exp 0/00000000", rf_we, rf_wd); end
    tick();
    idle_inputs();
    issue(0, 0, 3'b000, 32'h33, 32'h0, 5'd3, 1);
    tick();
    idle_inputs();
    settle();
    vecs++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h33) begin errs++; $display("FAIL rst_then_alu got %b/%0d/%h exp 1/3/00000033", rf_we, rf_wa, rf_wd); end
    tick();
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign();
    issue(1, 0, 3'b010, 32'h301, 32'h0, 5'd4, 1);
    tick();
    idle_inputs();
    settle();
    vecs++; if (dmem_req !== 1'b0 || misalign_err !== 1'b1 || rf_we !== 1'b0) begin errs++; $display("FAIL misalign_pulse got %b/%b/%b exp 0/1/0", dmem_req, misalign_err, rf_we); end
    tick();
    settle();
    vecs++; if (misalign_err !== 1'b0 || dmem_req !== 1'b0) begin errs++; $display("FAIL misalign_clear got %b/%b exp 0/0", misalign_err, dmem_req); end
    tick();
  endtask
`else
  task automatic test_misalign();
    issue(1, 0, 3'b010, 32'h301, 32'h0, 5'd4, 1);
    tick();
    idle_inputs();
    dmem_ready = 1;
    settle();
    vecs++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h300 || misalign_err !== 1'b0) begin errs++; $display("FAIL misalign_off got %b/%h/%b exp 1/00000300/0", dmem_req, dmem_addr, misalign_err); end
    tick();
    dmem_ready = 0; dmem_rvalid = 1; dmem_rdata = 32'h0BAD_F00D;
    settle();
    vecs++; if (rf_we !== 1'b1 || rf_wd !== 32'h0BAD_F00D) begin errs++; $display("FAIL misalign_off_wb got %b/%h exp 1/0badf00d", rf_we, rf_wd); end
    tick();
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load("lb",  3'b000, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
    test_load("lbu", 3'b100, 32'h103, 32'h80FF_0000, 32'h0000_0080);
    test_load("lh",  3'b001, 32'h002, 32'h8001_1234, 32'hFFFF_8001);
    test_load("lhu", 3'b101, 32'h000, 32'h8001_9234, 32'h0000_9234);
    test_store_half_stall();
    test_store_byte();
    test_lw_rd0_and_stray();
    test_reset_mid_access();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
